ct_mmu_sram_req_ctrl: RTL and testbench
=======================================

CT_MMU_SRAM_REQ_CTRL -- requirements
Module: ct_mmu_sram_req_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 8, SRAM address bits; DATA_WIDTH, 196, SRAM data bits; depth is fixed at 1<<ADDR_WIDTH.
REQ-002 One clock; reset is asynchronous and active-low: forever_cpuclk  in  1  clock, all state on rising edge; cpurst_b  in  1  async active-low reset.
REQ-003 req_vld  in  1  request valid; req_rdy  out  1  request accepted when req_vld & req_rdy.
REQ-004 req_wr  in  1  1=write, 0=read; req_addr  in  ADDR_WIDTH  entry index.
REQ-005 req_wdata  in  DATA_WIDTH  write data; req_wmask  in  DATA_WIDTH  active-high per-bit write enable.
REQ-006 rsp_vld  out  1  read data valid; rsp_rdy  in  1  consumer ready; rsp_rdata  out  DATA_WIDTH  read data.
REQ-007 inv_all  in  1  invalidate-all request (level, sampled in IDLE); inv_done  out  1  one-cycle pulse at sweep end; busy  out  1  high in any state but IDLE.
REQ-008 sram_cen  out  1  active-low chip enable; sram_gwen  out  1  active-low global write; sram_wen  out  DATA_WIDTH  active-low bit write enable; sram_a  out  ADDR_WIDTH; sram_d  out  DATA_WIDTH; sram_q  in  DATA_WIDTH  SRAM read data, valid the cycle after a read.

Function
REQ-009 FSM states SHALL be WAIT, INIT, IDLE, INV; WAIT->INIT unconditionally; INIT->IDLE and INV->IDLE after entry (1<<ADDR_WIDTH)-1 is written; IDLE->INV when inv_all=1.
REQ-010 In INIT/INV an 8-bit sweep counter SHALL start at 0 and increment each cycle; each cycle drives sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_a=counter, sram_d=0; sweep = 256 cycles.
REQ-011 inv_done SHALL pulse for exactly one cycle, the cycle after the last INV write; no pulse after INIT.
REQ-012 inv_all asserted during INIT or INV SHALL be ignored (no re-sweep, no extra inv_done).
REQ-013 req_rdy SHALL be 1 only in IDLE with inv_all=0, and for reads additionally only when (rsp_vld=0 | rsp_rdy=1).
REQ-014 Accepted write: same cycle drive sram_cen=0, sram_gwen=0, sram_wen=~req_wmask, sram_a=req_addr, sram_d=req_wdata; no response.
REQ-015 Accepted read: same cycle drive sram_cen=0, sram_gwen=1, sram_wen=all 1, sram_a=req_addr; rsp_vld=1 the next cycle (latency 1).
REQ-016 First response cycle: rsp_rdata=sram_q; if rsp_rdy=0, sram_q SHALL be captured into a hold register and rsp_rdata sourced from it until handshake.
REQ-017 rsp_vld SHALL stay 1 with stable rsp_rdata until rsp_rdy=1; back-to-back reads with rsp_rdy=1 SHALL sustain one read per cycle.
REQ-018 Writes and INV sweep writes issued while a response is pending SHALL not corrupt it (hold register captured before sram_q changes).
REQ-019 inv_all and req_vld in the same IDLE cycle: INV wins, request not accepted, sweep starts that cycle.
REQ-020 Idle cycles SHALL drive sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
REQ-021 rsp_rdata SHALL be 0 whenever rsp_vld=0.

Reset
REQ-022 While cpurst_b=0: state=WAIT, counter=0, hold register=0, rsp_vld=0, req_rdy=0, inv_done=0, busy=1, sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0, rsp_rdata=0.
REQ-023 Reset asserted mid-sweep or mid-response SHALL abandon it; a full INIT sweep follows release.

Structure
REQ-024 FSM state encoding, ADDR_WIDTH/DATA_WIDTH defaults and depth constant SHALL live in shared package ct_mmu_sram_pkg.
REQ-025 Response valid/hold logic SHALL be one sub-module ct_mmu_sram_rsp_hold; SRAM macro stays outside this block.

Verification
REQ-026 Release reset -> WAIT 1 cycle, 256 INIT zero-writes at addr 0..255, busy falls, req_rdy=1 on cycle 258; no inv_done.
REQ-027 Write addr 0x12 data all-ones mask 0x0F (low bits) then read 0x12 -> rsp_vld next cycle, rsp_rdata=0x0F.
REQ-028 Read 0x12 with rsp_rdy=0 for 5 cycles while writing 0x12 with all-ones -> rsp_rdata stays 0x0F; reads blocked; rsp_vld drops after handshake.
REQ-029 Reads 0x00..0x0F back-to-back, rsp_rdy=1 -> 16 responses on consecutive cycles, correct order.
REQ-030 inv_all with req_vld same IDLE cycle -> req_rdy=0, 256 zero-writes, inv_done single pulse; read of any entry returns 0.
REQ-031 Assert cpurst_b=0 at sweep count 100 -> outputs at REQ-022 values immediately; release -> full 256-entry INIT sweep from 0.

Source files
------------

// File: rtl/ct_mmu_sram_pkg.sv
// Shared types and sizing for the MMU SRAM request controller.
// Holds the controller FSM encoding and default geometry of the SRAM array.
package ct_mmu_sram_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 196;
  localparam int DEPTH          = 1 << ADDR_WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_INIT = 2'd1,
    ST_IDLE = 2'd2,
    ST_INV  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/ct_mmu_sram_rsp_hold.sv
// Read response valid/hold: first response cycle forwards sram_q, a stalled response is held.
// Latency 1 from accepted read; rsp_vld stays high with stable data until rsp_rdy.
module ct_mmu_sram_rsp_hold
  import ct_mmu_sram_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  rd_fire_i,
  input  logic                  rsp_rdy_i,
  input  logic [DATA_WIDTH-1:0] sram_q_i,
  output logic                  rsp_vld_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o
);

  logic                  vld_q, vld_d;
  logic                  first_q, first_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  always_comb begin
    vld_d   = rd_fire_i | (vld_q & ~rsp_rdy_i);
    first_d = rd_fire_i;
    hold_d  = hold_q;
    // sram_q is only trusted in the cycle right after the read; snapshot it if stalled
    if (vld_q && first_q && !rsp_rdy_i) begin
      hold_d = sram_q_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      first_q <= first_d;
      hold_q  <= hold_d;
    end
  end

  assign rsp_vld_o   = vld_q;
  assign rsp_rdata_o = !vld_q ? '0 : (first_q ? sram_q_i : hold_q);

endmodule

// File: rtl/ct_mmu_sram_req_ctrl.sv
// MMU SRAM request controller: zero-fill sweep after reset and on inv_all, then single-port rd/wr.
// Reads return one cycle after acceptance; reads stall while a response is held, writes never do.
module ct_mmu_sram_req_ctrl
  import ct_mmu_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  inv_all,
  output logic                  inv_done,
  output logic                  busy,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  inv_done_q, inv_done_d;
  logic                  sweep;
  logic                  rd_fire;
  logic                  wr_fire;

  assign sweep = (state_q == ST_INIT) || (state_q == ST_INV);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inv_done_d = 1'b0;
    case (state_q)
      ST_WAIT: state_d = ST_INIT;
      ST_INIT, ST_INV: begin
        // counter wraps back to zero on the last entry, ready for the next sweep
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d    = ST_IDLE;
          inv_done_d = (state_q == ST_INV);
        end
      end
      ST_IDLE: if (inv_all) state_d = ST_INV;
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= ST_WAIT;
      cnt_q      <= '0;
      inv_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inv_done_q <= inv_done_d;
    end
  end

  assign req_rdy = (state_q == ST_IDLE) && !inv_all && (req_wr || !rsp_vld || rsp_rdy);
  assign rd_fire = req_vld && req_rdy && !req_wr;
  assign wr_fire = req_vld && req_rdy && req_wr;

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (sweep) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = cnt_q;
    end else if (wr_fire) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~req_wmask;
      sram_a    = req_addr;
      sram_d    = req_wdata;
    end else if (rd_fire) begin
      sram_cen  = 1'b0;
      sram_a    = req_addr;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign inv_done = inv_done_q;

  ct_mmu_sram_rsp_hold #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_hold (
    .clk_i       (forever_cpuclk),
    .rst_n_i     (cpurst_b),
    .rd_fire_i   (rd_fire),
    .rsp_rdy_i   (rsp_rdy),
    .sram_q_i    (sram_q),
    .rsp_vld_o   (rsp_vld),
    .rsp_rdata_o (rsp_rdata)
  );

endmodule

// File: tb/tb_ct_mmu_sram_req_ctrl.sv
// Directed bench for ct_mmu_sram_req_ctrl with a behavioural single-port SRAM attached.
module tb_ct_mmu_sram_req_ctrl;
  import ct_mmu_sram_pkg::*;

  localparam int AW = ADDR_WIDTH_DEF;
  localparam int DW = DATA_WIDTH_DEF;
  localparam logic [DW-1:0] W_ONES = {DW{1'b1}};

  logic          clk;
  logic          rst_b;
  logic          req_vld, req_rdy, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, req_wmask;
  logic          rsp_vld, rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          inv_all, inv_done, busy;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d, sram_q;
  logic [AW-1:0] sram_a;

  int n_chk  = 0;
  int n_pass = 0;

  ct_mmu_sram_req_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_rdata      (rsp_rdata),
    .inv_all        (inv_all),
    .inv_done       (inv_done),
    .busy           (busy),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_a         (sram_a),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: q updates on reads, and shows the freshly written word on writes
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = W_ONES;
    sram_q = '0;
  end
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
        sram_q      <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      end else begin
        sram_q <= mem[sram_a];
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [DW-1:0] v;
    v = DW'(i + 1) << 120;
    v = v | DW'(32'h00a5_0000 + i);
    return v;
  endfunction

  task automatic reset_check(input string tag);
    chk({tag, "_req_rdy"},   req_rdy,   0);
    chk({tag, "_rsp_vld"},   rsp_vld,   0);
    chk({tag, "_inv_done"},  inv_done,  0);
    chk({tag, "_busy"},      busy,      1);
    chk({tag, "_cen"},       sram_cen,  1);
    chk({tag, "_gwen"},      sram_gwen, 1);
    chk({tag, "_wen"},       sram_wen,  W_ONES);
    chk({tag, "_a"},         sram_a,    0);
    chk({tag, "_d"},         sram_d,    0);
    chk({tag, "_rdata"},     rsp_rdata, 0);
  endtask

  // Entered at posedge+1 of the first cycle after reset release (the WAIT cycle)
  task automatic sweep_check(input string tag);
    int errs  = 0;
    int dones = 0;
    for (int c = 1; c <= DEPTH + 2; c++) begin
      @(negedge clk);
      if (inv_done) dones++;
      if (c == 1) begin
        if (!busy || !sram_cen || req_rdy) errs++;
      end else if (c <= DEPTH + 1) begin
        if (sram_cen || sram_gwen || sram_wen != '0 || sram_d != '0 ||
            sram_a != AW'(c - 2) || !busy || req_rdy) errs++;
      end else begin
        chk({tag, "_rdy_last"},  req_rdy, 1);
        chk({tag, "_busy_last"}, busy,    0);
      end
      step();
    end
    chk({tag, "_sweep_errs"}, errs,  0);
    chk({tag, "_inv_done"},   dones, 0);
  endtask

  task automatic do_write(input string tag, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m);
    req_vld = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
    @(negedge clk);
    chk({tag, "_rdy"}, req_rdy, 1);
    step();
    req_vld = 1'b0; req_wr = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = a; rsp_rdy = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy"}, req_rdy, 1);
    step();
    req_vld = 1'b0;
    @(negedge clk);
    chk({tag, "_vld"},   rsp_vld,   1);
    chk({tag, "_rdata"}, rsp_rdata, exp);
    step();
  endtask

  initial begin
    int wcnt, errs, pulses, found;
    rst_b = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_rdy = 1'b0; inv_all = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_check("rst");
    step();
    rst_b = 1'b1;
    sweep_check("init");

    // masked write then read back
    do_write("wr12", 8'h12, W_ONES, DW'(8'h0F));
    do_read("rd12", 8'h12, DW'(8'h0F));

    // stalled response survives a write to the same entry
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 8'h12; rsp_rdy = 1'b0;
    @(negedge clk);
    chk("stall_rd_rdy", req_rdy, 1);
    step();
    req_wr = 1'b1; req_wdata = W_ONES; req_wmask = W_ONES;
    @(negedge clk);
    chk("stall_first_vld",   rsp_vld,   1);
    chk("stall_first_rdata", rsp_rdata, DW'(8'h0F));
    chk("stall_wr_rdy",      req_rdy,   1);
    step();
    req_wr = 1'b0; req_addr = 8'h00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_rd_blocked", req_rdy,   0);
      chk("stall_no_access",  sram_cen,  1);
      chk("stall_vld",        rsp_vld,   1);
      chk("stall_rdata",      rsp_rdata, DW'(8'h0F));
      step();
    end
    req_vld = 1'b0; rsp_rdy = 1'b1;
    @(negedge clk);
    chk("stall_hs_vld",   rsp_vld,   1);
    chk("stall_hs_rdata", rsp_rdata, DW'(8'h0F));
    step();
    @(negedge clk);
    chk("post_hs_vld",   rsp_vld,   0);
    chk("post_hs_rdata", rsp_rdata, 0);
    step();

    // back-to-back reads
    for (int i = 0; i < 16; i++) do_write("fill", AW'(i), pat(i), W_ONES);
    for (int i = 0; i <= 16; i++) begin
      req_vld = (i < 16); req_wr = 1'b0; req_addr = AW'(i); rsp_rdy = 1'b1;
      @(negedge clk);
      if (i < 16) chk("b2b_rdy", req_rdy, 1);
      if (i > 0) begin
        chk("b2b_vld",   rsp_vld,   1);
        chk("b2b_rdata", rsp_rdata, pat(i - 1));
      end
      step();
    end
    req_vld = 1'b0;

    // invalidate wins over a same-cycle request; inv_all held into the sweep is ignored
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 8'h05; req_wdata = W_ONES; req_wmask = W_ONES;
    inv_all = 1'b1;
    wcnt = 0; errs = 0; pulses = 0;
    for (int c = 0; c < DEPTH + 20; c++) begin
      @(negedge clk);
      if (c == 0) chk("inv_req_rdy", req_rdy, 0);
      if (!sram_cen) begin
        if (sram_gwen || sram_wen != '0 || sram_d != '0 || sram_a != AW'(wcnt)) errs++;
        wcnt++;
      end
      if (inv_done) begin
        pulses++;
        if (busy) errs++;
      end
      step();
      if (c == 0) req_vld = 1'b0;
      if (c == 10) inv_all = 1'b0;
    end
    chk("inv_writes",   wcnt,   DEPTH);
    chk("inv_errs",     errs,   0);
    chk("inv_done_cnt", pulses, 1);
    do_read("inv_rd12", 8'h12, '0);
    do_read("inv_rd05", 8'h05, '0);
    do_read("inv_rd03", 8'h03, '0);

    // reset in the middle of a sweep
    inv_all = 1'b1;
    found = 0;
    for (int k = 0; k < DEPTH + 10; k++) begin
      @(negedge clk);
      if (!sram_cen && sram_a == AW'(100)) begin
        found = 1;
        break;
      end
      step();
      inv_all = 1'b0;
    end
    chk("find_cnt100", found, 1);
    inv_all = 1'b0;
    rst_b = 1'b0;
    #1;
    reset_check("rst_mid");
    step();
    step();
    rst_b = 1'b1;
    sweep_check("reinit");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
